// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU control unit:
// control-bit indices, opcodes, fetch words and instruction lengths.
package cpu_ctrl_pkg;

    localparam int NUM_STEPS = 5;
    localparam int STEP_W    = 3;
    localparam int OPCODE_W  = 4;
    localparam int CTRL_W    = 16;

    localparam int CTRL_HLT = 0;
    localparam int CTRL_MI  = 1;
    localparam int CTRL_RI  = 2;
    localparam int CTRL_RO  = 3;
    localparam int CTRL_IO  = 4;
    localparam int CTRL_II  = 5;
    localparam int CTRL_AI  = 6;
    localparam int CTRL_AO  = 7;
    localparam int CTRL_EO  = 8;
    localparam int CTRL_SU  = 9;
    localparam int CTRL_BI  = 10;
    localparam int CTRL_OI  = 11;
    localparam int CTRL_CE  = 12;
    localparam int CTRL_CO  = 13;
    localparam int CTRL_J   = 14;
    localparam int CTRL_FI  = 15;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    function automatic logic [CTRL_W-1:0] cb(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    localparam logic [CTRL_W-1:0] FETCH0   = cb(CTRL_CO) | cb(CTRL_MI);
    localparam logic [CTRL_W-1:0] FETCH1   = cb(CTRL_RO) | cb(CTRL_II)
                                           | cb(CTRL_CE);
    localparam logic [CTRL_W-1:0] HLT_WORD = cb(CTRL_HLT);

    localparam logic [STEP_W-1:0] LEN_NOP = 3'd2;
    localparam logic [STEP_W-1:0] LEN_LDA = 3'd4;
    localparam logic [STEP_W-1:0] LEN_ADD = 3'd5;
    localparam logic [STEP_W-1:0] LEN_SUB = 3'd5;
    localparam logic [STEP_W-1:0] LEN_STA = 3'd4;
    localparam logic [STEP_W-1:0] LEN_LDI = 3'd3;
    localparam logic [STEP_W-1:0] LEN_JMP = 3'd3;
    localparam logic [STEP_W-1:0] LEN_JC  = 3'd3;
    localparam logic [STEP_W-1:0] LEN_JZ  = 3'd3;
    localparam logic [STEP_W-1:0] LEN_OUT = 3'd3;
    localparam logic [STEP_W-1:0] LEN_HLT = 3'd3;

    function automatic logic [STEP_W-1:0] instr_len(
        input logic [OPCODE_W-1:0] op
    );
        logic [STEP_W-1:0] len;
        len = LEN_NOP;
        unique case (op)
            OP_LDA:  len = LEN_LDA;
            OP_ADD:  len = LEN_ADD;
            OP_SUB:  len = LEN_SUB;
            OP_STA:  len = LEN_STA;
            OP_LDI:  len = LEN_LDI;
            OP_JMP:  len = LEN_JMP;
            OP_JC:   len = LEN_JC;
            OP_JZ:   len = LEN_JZ;
            OP_OUT:  len = LEN_OUT;
            OP_HLT:  len = LEN_HLT;
            default: len = LEN_NOP;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/cpu_control_unit_rom.sv
// Microcode table: (step, opcode, flags) -> control word and an
// end-of-instruction marker. Purely combinational.
module cpu_microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0]   step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                last_step
);

    logic [STEP_W-1:0] len;
    logic [STEP_W:0]   step_nxt;

    always_comb begin
        ctrl     = '0;
        len      = instr_len(opcode);
        step_nxt = {1'b0, step} + 4'd1;
        // Out-of-range steps also wrap so the counter can never stick.
        last_step = (step_nxt >= {1'b0, len})
                  || (step_nxt >= (STEP_W+1)'(NUM_STEPS));

        unique case (step)
            3'd0: ctrl = FETCH0;
            3'd1: ctrl = FETCH1;
            3'd2: begin
                unique case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cb(CTRL_IO) | cb(CTRL_MI);
                    OP_LDI:
                        ctrl = cb(CTRL_IO) | cb(CTRL_AI);
                    OP_JMP:
                        ctrl = cb(CTRL_IO) | cb(CTRL_J);
                    OP_JC:
                        ctrl = flag_c ? (cb(CTRL_IO) | cb(CTRL_J)) : '0;
                    OP_JZ:
                        ctrl = flag_z ? (cb(CTRL_IO) | cb(CTRL_J)) : '0;
                    OP_OUT:
                        ctrl = cb(CTRL_AO) | cb(CTRL_OI);
                    OP_HLT:
                        ctrl = HLT_WORD;
                    default:
                        ctrl = '0;
                endcase
            end
            3'd3: begin
                unique case (opcode)
                    OP_LDA:         ctrl = cb(CTRL_RO) | cb(CTRL_AI);
                    OP_ADD, OP_SUB: ctrl = cb(CTRL_RO) | cb(CTRL_BI);
                    OP_STA:         ctrl = cb(CTRL_AO) | cb(CTRL_RI);
                    default:        ctrl = '0;
                endcase
            end
            3'd4: begin
                unique case (opcode)
                    OP_ADD:
                        ctrl = cb(CTRL_EO) | cb(CTRL_AI) | cb(CTRL_FI);
                    OP_SUB:
                        ctrl = cb(CTRL_EO) | cb(CTRL_AI) | cb(CTRL_FI)
                             | cb(CTRL_SU);
                    default:
                        ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// T-state sequencer for the 8-bit CPU: step counter, halt latch and
// the combinational control word from the microcode table.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic              enter_halt;

    cpu_microcode_rom u_rom (
        .step      (step_q),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (rom_ctrl),
        .last_step (rom_last)
    );

    always_comb begin
        step_d     = step_q;
        halted_d   = halted_q;
        enter_halt = (step_q == 3'd2) && (opcode == OP_HLT);
        if (halted_q) begin
            step_d = step_q;
        end else if (enter_halt) begin
            // Freeze on T2 so the display shows where the CPU stopped.
            halted_d = 1'b1;
        end else if (rom_last) begin
            step_d = '0;
        end else begin
            step_d = step_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign ctrl   = halted_q ? HLT_WORD : rom_ctrl;
    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: fetch/execute sequences,
// conditional jumps, halt, mid-instruction reset and a full sweep.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] BUS_MASK = 16'h2198;

    cpu_control_unit dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [15:0] exp_ctrl(input logic [3:0] op,
        input int st, input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        if (st == 0) w = 16'h2002;
        else if (st == 1) w = 16'h1028;
        else if (st == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: w = 16'h0012;
                4'h5: w = 16'h0050;
                4'h6: w = 16'h4010;
                4'h7: w = c ? 16'h4010 : 16'h0000;
                4'h8: w = z ? 16'h4010 : 16'h0000;
                4'hE: w = 16'h0880;
                4'hF: w = 16'h0001;
                default: w = 16'h0000;
            endcase
        end else if (st == 3) begin
            case (op)
                4'h1: w = 16'h0048;
                4'h2, 4'h3: w = 16'h0408;
                4'h4: w = 16'h0084;
                default: w = 16'h0000;
            endcase
        end else if (st == 4) begin
            case (op)
                4'h2: w = 16'h8140;
                4'h3: w = 16'h8340;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
            default: return 2;
        endcase
    endfunction

    // ev packs the expected words, T0 in the low 16 bits.
    task automatic run(input string tag, input logic [3:0] op,
                       input logic c, input logic z, input int n,
                       input logic [79:0] ev);
        opcode = op;
        flag_c = c;
        flag_z = z;
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("%s_ctrl_T%0d", tag, i), 32'(ctrl),
                32'(ev[16*i +: 16]));
            chk($sformatf("%s_step_T%0d", tag, i), 32'(step), 32'(i));
            tick();
        end
        chk({tag, "_wrap_step"}, 32'(step), 32'd0);
        chk({tag, "_wrap_ctrl"}, 32'(ctrl), 32'h2002);
    endtask

    initial begin
        int   n;
        logic c;
        logic z;
        rst    = 1'b1;
        opcode = 4'h0;
        flag_c = 1'b0;
        flag_z = 1'b0;

        do_reset();
        chk("rst_ctrl", 32'(ctrl), 32'h2002);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        run("lda", 4'h1, 1'b0, 1'b0, 4,
            {16'h0, 16'h0048, 16'h0012, 16'h1028, 16'h2002});
        run("add", 4'h2, 1'b0, 1'b0, 5,
            {16'h8140, 16'h0408, 16'h0012, 16'h1028, 16'h2002});
        run("sub", 4'h3, 1'b1, 1'b1, 5,
            {16'h8340, 16'h0408, 16'h0012, 16'h1028, 16'h2002});
        run("jc1", 4'h7, 1'b1, 1'b0, 3,
            {16'h0, 16'h0, 16'h4010, 16'h1028, 16'h2002});
        run("jc0", 4'h7, 1'b0, 1'b1, 3,
            {16'h0, 16'h0, 16'h0000, 16'h1028, 16'h2002});
        run("jz1", 4'h8, 1'b0, 1'b1, 3,
            {16'h0, 16'h0, 16'h4010, 16'h1028, 16'h2002});
        run("jz0", 4'h8, 1'b1, 1'b0, 3,
            {16'h0, 16'h0, 16'h0000, 16'h1028, 16'h2002});

        // Halt and hold with random inputs
        opcode = 4'hF;
        tick();
        tick();
        chk("hlt_T2_ctrl", 32'(ctrl), 32'h0001);
        chk("hlt_T2_halted", 32'(halted), 32'd0);
        tick();
        chk("hlt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            #1;
            chk("hold_ctrl", 32'(ctrl), 32'h0001);
            chk("hold_step", 32'(step), 32'd2);
            chk("hold_halted", 32'(halted), 32'd1);
            tick();
        end
        do_reset();
        chk("unhalt_ctrl", 32'(ctrl), 32'h2002);
        chk("unhalt_step", 32'(step), 32'd0);
        chk("unhalt_halted", 32'(halted), 32'd0);

        // Reset in T3 of ADD
        opcode = 4'h2;
        tick();
        tick();
        tick();
        chk("addrst_T3", 32'(ctrl), 32'h0408);
        do_reset();
        chk("addrst_step", 32'(step), 32'd0);
        chk("addrst_ctrl", 32'(ctrl), 32'h2002);
        tick();
        chk("addrst_next", 32'(ctrl), 32'h1028);

        // Sweep every opcode and flag pair
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 4; f++) begin
                c = f[0];
                z = f[1];
                do_reset();
                flag_c = c;
                flag_z = z;
                n = 0;
                for (int s = 0; s < 6; s++) begin
                    if (s < 2) opcode = 4'($urandom_range(0, 15));
                    else opcode = 4'(op);
                    #1;
                    chk($sformatf("sw_ctrl_op%0h_f%0d_T%0d", op, f, s),
                        32'(ctrl), 32'(exp_ctrl(4'(op), s, c, z)));
                    chk($sformatf("sw_bus_op%0h_T%0d", op, s),
                        32'($countones(ctrl & BUS_MASK) <= 1), 32'd1);
                    opcode = 4'(op);
                    n = s + 1;
                    tick();
                    if (op == 15 && s == 2) begin
                        chk("sw_hlt_halted", 32'(halted), 32'd1);
                        chk("sw_hlt_step", 32'(step), 32'd2);
                        break;
                    end
                    if (step == 3'd0) break;
                end
                chk($sformatf("sw_len_op%0h_f%0d", op, f), 32'(n),
                    32'(exp_len(4'(op))));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Microcoded sequencer for the 8-bit CPU. Steps the fetch/decode/execute T-states and drives the control word that gates the MAR, RAM, IR, PC, A/B registers, ALU and output register onto and off the shared 8-bit bus.
- Decodes the 4-bit opcode from the IR high nibble and samples the carry/zero flags for conditional jumps.
- One control word per clock. Datapath registers capture on the next posedge.

Parameters:
- NUM_STEPS, 5, maximum T-states per instruction (T0..T4); step counter width is 3.
- OPCODE_W, 4, opcode width (IR[7:4]).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[7:4]; stable from T2 onward.
- flag_c  in  1  carry flag from the flags register.
- flag_z  in  1  zero flag from the flags register.
- ctrl  out  16  control word; bit map defined in the package.
- step  out  3  current T-state, for debug and display.
- halted  out  1  high while in the HALT state.

Behaviour:
- Control bit map:
  - 0 hlt, 1 mi (MAR in), 2 ri (RAM in), 3 ro (RAM out), 4 io (IR low-nibble out), 5 ii (IR in)
  - 6 ai, 7 ao, 8 eo (ALU out), 9 su, 10 bi, 11 oi (output reg in)
  - 12 ce (PC count), 13 co (PC out), 14 j (PC load), 15 fi (flags in)
- State: step counter 0..4 plus a halted bit. ctrl is a pure combinational function of (step, opcode, flags, halted); no output register. Zero cycles from state to ctrl.
- Reset (rst=1 at a posedge): step<=0, halted<=0. This applies mid-instruction and while halted. After reset: ctrl=co|mi (0x2002), step=0, halted=0.
- Fetch, identical for all opcodes:
  - T0 = co|mi
  - T1 = ro|ii|ce
- Execute steps and instruction length:
  - 0x0 NOP: len 2.
  - 0x1 LDA: T2 io|mi; T3 ro|ai. len 4.
  - 0x2 ADD: T2 io|mi; T3 ro|bi; T4 eo|ai|fi. len 5.
  - 0x3 SUB: as ADD, with su added at T4. len 5.
  - 0x4 STA: T2 io|mi; T3 ao|ri. len 4.
  - 0x5 LDI: T2 io|ai. len 3.
  - 0x6 JMP: T2 io|j. len 3.
  - 0x7 JC: T2 io|j if flag_c=1, else ctrl=0. len 3.
  - 0x8 JZ: T2 io|j if flag_z=1, else ctrl=0. len 3.
  - 0x9-0xD: decode as NOP, len 2. No other side effects.
  - 0xE OUT: T2 ao|oi. len 3.
  - 0xF HLT: T2 hlt; halted<=1 at the end of T2.
- Step advance: if step==len-1, step<=0; else step<=step+1. The last step of one instruction is directly followed by T0 of the next, with no bubble.
- Flag sampling: flags are sampled combinationally during T2 only. A flag change in another step does not affect a jump.
- HALT state:
  - ctrl=hlt (0x0001), step frozen at 2, halted=1.
  - Opcode and flag inputs are ignored. Only rst exits HALT.
- Bus-driver rule: at most one of {ro, io, ao, eo, co} is set in any control word. This is a structural property of the microcode table.
- Opcode is don't-care during T0/T1; ctrl in those steps must not depend on it.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - control-bit index constants (CTRL_HLT..CTRL_FI)
  - opcode constants (OP_NOP..OP_HLT)
  - FETCH0/FETCH1 control-word constants
  - instruction-length constants
- Sub-module cpu_microcode_rom: purely combinational map (step, opcode, flag_c, flag_z) -> {ctrl[15:0], last_step}.
- cpu_control_unit owns the step counter, the halted bit and reset handling.

Test Plan:
- Reset then LDA (opcode 0x1), 4 cycles -> ctrl sequence 0x2002, 0x1028, 0x0012, 0x0048, then step=0 with ctrl 0x2002.
- ADD (0x2) -> T2..T4 = 0x0012, 0x0408, 0x8140; SUB (0x3) -> T4 = 0x8340; 5-cycle instruction.
- JC (0x7): flag_c=1 -> T2 ctrl 0x4010. flag_c=0 -> T2 ctrl 0x0000. Both return to T0 the next cycle. Repeat for JZ (0x8) with flag_z.
- HLT (0xF) -> T2 ctrl 0x0001; halted=1 from the next cycle. Hold 20 cycles with random opcode/flags: ctrl stays 0x0001, step stays 2. Assert rst -> step=0, halted=0, ctrl 0x2002.
- Assert rst during T3 of ADD -> next cycle step=0, ctrl 0x2002. No eo/ai is issued after reset.
- Sweep all 16 opcodes × all steps × all flag combinations -> check length table, unused opcodes 0x9-0xD as 2-step NOP, and at most one bus driver per control word.
